// File: rtl/breakout_pkg.sv
// Shared constants for the breakout game path: state codes, parameter defaults and screen size.
package breakout_pkg;

  typedef enum logic [2:0] {
    StNewgame = 3'd0,
    StPlay    = 3'd1,
    StNewball = 3'd2,
    StOver    = 3'd3,
    StWin     = 3'd4
  } state_e;

  localparam int unsigned BALLS_INIT_DEF  = 3;
  localparam int unsigned DELAY_TICKS_DEF = 120;
  localparam int unsigned NUM_BRICKS_DEF  = 48;

  localparam int unsigned MAX_X = 640;
  localparam int unsigned MAX_Y = 480;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter, 00..99 with wrap; clr has priority over inc.
module bcd2_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  logic [3:0] d1_q, d1_d;
  logic [3:0] d0_q, d0_d;

  always_comb begin
    d1_d = d1_q;
    d0_d = d0_q;
    if (clr) begin
      d1_d = 4'd0;
      d0_d = 4'd0;
    end else if (inc) begin
      if (d0_q == 4'd9) begin
        d0_d = 4'd0;
        d1_d = (d1_q == 4'd9) ? 4'd0 : d1_q + 4'd1;
      end else begin
        d0_d = d0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d1_q <= 4'd0;
      d0_q <= 4'd0;
    end else begin
      d1_q <= d1_d;
      d0_q <= d0_d;
    end
  end

  assign d1 = d1_q;
  assign d0 = d0_q;

endmodule

// File: rtl/breakout_ctrl.sv
// Game-phase controller for breakout: start/play/relaunch/over/win, BCD score and ball count.
// Define BREAKOUT_WIN_EN to add the bricks_left counter/port and the WIN phase.
module breakout_ctrl
  import breakout_pkg::*;
#(
  parameter int unsigned BALLS_INIT  = BALLS_INIT_DEF,
  parameter int unsigned DELAY_TICKS = DELAY_TICKS_DEF,
  parameter int unsigned NUM_BRICKS  = NUM_BRICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn,
  input  logic       refr_tick,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [2:0] game_state,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls
`ifdef BREAKOUT_WIN_EN
  ,
  output logic [5:0] bricks_left
`endif
);

  localparam logic [1:0] BallsInit  = 2'(BALLS_INIT);
  localparam logic [7:0] DelayInit  = 8'(DELAY_TICKS);

  state_e     state_q, state_d;
  logic       hit_q, miss_q;
  logic       hit_p, miss_p;
  logic [7:0] tmr_q, tmr_d;
  logic       tmr_done;
  logic [1:0] balls_q, balls_d;
  logic       score_clr, score_inc;
  logic       last_brick;
  logic       btn_press;

`ifdef BREAKOUT_WIN_EN
  localparam logic [5:0] BricksInit = 6'(NUM_BRICKS);
  logic [5:0] bricks_q, bricks_d;
`endif

  assign hit_p     = hit & ~hit_q;
  assign miss_p    = miss & ~miss_q;
  assign tmr_done  = (tmr_q == 8'd0);
  assign btn_press = (btn != 5'd0);

  always_comb begin
    state_d    = state_q;
    balls_d    = balls_q;
    score_clr  = 1'b0;
    score_inc  = 1'b0;
    last_brick = 1'b0;
`ifdef BREAKOUT_WIN_EN
    bricks_d   = bricks_q;
`endif
    unique case (state_q)
      StNewgame: begin
        if (btn_press) begin
          state_d   = StPlay;
          score_clr = 1'b1;
`ifdef BREAKOUT_WIN_EN
          bricks_d  = BricksInit;
`endif
        end
      end
      StPlay: begin
        if (hit_p) begin
          score_inc = 1'b1;
`ifdef BREAKOUT_WIN_EN
          if (bricks_q != 6'd0) begin
            bricks_d   = bricks_q - 6'd1;
            last_brick = (bricks_q == 6'd1);
          end
`endif
        end
        // The last brick wins even if the ball is lost on the same cycle.
        if (last_brick) begin
          state_d = StWin;
        end else if (miss_p) begin
          if (balls_q == 2'd1) begin
            state_d = StOver;
            balls_d = 2'd0;
          end else begin
            state_d = StNewball;
            balls_d = balls_q - 2'd1;
          end
        end
      end
      StNewball: begin
        if (tmr_done && btn_press) state_d = StPlay;
      end
      StOver, StWin: begin
        if (tmr_done) state_d = StNewgame;
      end
      default: state_d = StNewgame;
    endcase

    if (state_d == StNewgame) balls_d = BallsInit;

    // Entry load wins over a coincident refresh tick.
    tmr_d = tmr_q;
    if ((state_d != state_q) &&
        (state_d == StNewball || state_d == StOver || state_d == StWin)) begin
      tmr_d = DelayInit;
    end else if (refr_tick && !tmr_done) begin
      tmr_d = tmr_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StNewgame;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      tmr_q    <= 8'd0;
      balls_q  <= BallsInit;
`ifdef BREAKOUT_WIN_EN
      bricks_q <= BricksInit;
`endif
    end else begin
      state_q  <= state_d;
      hit_q    <= hit;
      miss_q   <= miss;
      tmr_q    <= tmr_d;
      balls_q  <= balls_d;
`ifdef BREAKOUT_WIN_EN
      bricks_q <= bricks_d;
`endif
    end
  end

  bcd2_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .d1    (score_d1),
    .d0    (score_d0)
  );

  assign gra_still  = (state_q != StPlay);
  assign game_state = state_q;
  assign balls      = balls_q;
`ifdef BREAKOUT_WIN_EN
  assign bricks_left = bricks_q;
`endif

endmodule
